alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Sequential execution unit that consumes the 4-bit ALU operation codes produced by the ALU control decoder and executes them on two operands.
- Single-cycle ops complete in one registered cycle; SRL/SLL run iteratively, shifting one bit per clock.
- Uses a start/busy/done handshake so a multicycle datapath controller can issue work and wait for results.
- Sits beside the existing combinational ALU as the multicycle-path alternative.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, 5, shift-amount width taken from B_i[SHAMT_WIDTH-1:0]; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  request; accepted only when state is IDLE.
- ALU_Operation_i  input  4  operation code; sampled on accept.
- A_i  input  DATA_WIDTH  operand A; sampled on accept.
- B_i  input  DATA_WIDTH  operand B or shift amount; sampled on accept.
- busy_o  output  1  high whenever state != IDLE.
- done_o  output  1  one-cycle pulse; ALU_Result_o is valid from this cycle on.
- ALU_Result_o  output  DATA_WIDTH  registered result, held until the next accept.
- Zero_o  output  1  (ALU_Result_o == 0), derived from the registered result.

Behaviour:
- Reset (reset=0, any time, including mid-shift):
  - state=IDLE; shift register, counter and ALU_Result_o cleared to 0.
  - busy_o=0, done_o=0, Zero_o=1.
  - The in-flight operation is discarded, with no done pulse.
- Opcodes (shared with the decoder):
  - 0000 ADD A+B; 0001 SUB A-B; 0010 AND; 0011 OR; 0101 LUI, result=B.
  - 0110 SRL, logical right shift of A by shamt; 0111 SLL, left shift of A by shamt.
  - Any other code: result=0, completes as single-cycle.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH; no carry or overflow outputs.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE & start_i, non-shift op: compute and register the result at the accept edge; go to DONE.
  - IDLE & start_i, shift op: load A into the shift register and shamt into the counter.
    - shamt==0: register result=A and go to DONE.
    - Otherwise go to SHIFT.
  - SHIFT: each edge shifts the register by one bit in the op direction and decrements the counter.
    - When the counter reaches 0, the result register takes the final value and the state goes to DONE.
  - DONE: done_o=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency, counted from the accept edge k:
  - Non-shift or shamt==0: done_o high during cycle k+1.
  - Shift by n: done_o high during cycle k+1+n. Worst case is DATA_WIDTH cycles (n=31).
- Handshake rules:
  - start_i is ignored in SHIFT and in DONE; it is not queued.
  - A new start is accepted only in IDLE, so back-to-back ops have a minimum 2-cycle issue interval.
  - Operand inputs may change freely after the accept edge.
- ALU_Result_o updates only at completion (it does not track intermediate shift values) and at reset.
- Zero_o is purely combinational from ALU_Result_o.

Decomposition:
- Shared package holds:
  - opcode localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_LUI, ALU_SRL, ALU_SLL);
  - FSM state encoding;
  - DATA_WIDTH default.
- The decoder is updated to import the same opcode constants.
- One natural sub-module: alu_shift_iter, which holds the shift register, down-counter and direction bit, with load/step inputs and a last flag.

Test Plan:
- Reset released, then start ADD with A=5, B=7 → done_o in the cycle after accept, ALU_Result_o=12, Zero_o=0, busy_o high for one cycle.
- SUB with A=9, B=9 → ALU_Result_o=0, Zero_o=1; then SUB with A=0, B=1 → 0xFFFFFFFF.
- SLL with A=0x1, B=31 → done_o exactly 32 cycles after accept, result 0x80000000; start_i pulses during SHIFT are ignored and the result is unchanged.
- SRL with A=0x80000000, B=0x20 (shamt=0) → result 0x80000000 one cycle after accept; LUI with B=0x12345000 → 0x12345000.
- Reset asserted mid-SRL (A=0xF0, B=4, after 2 shift cycles) → immediately state=IDLE, busy_o=0, ALU_Result_o=0; no done_o after release.
- Undefined opcode 0100 with A=3, B=4 → result 0 with a normal one-cycle done_o; then AND with A=0xF0F0, B=0xFF00 → 0xF000.

Source files
------------

// File: rtl/alu_seq_exec_pkg.sv
// Shared opcode and FSM constants for the ALU control decoder and
// the sequential execution unit.
package alu_seq_exec_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_LUI = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_seq_exec_if.sv
// Start/busy/done request bundle between a multicycle controller
// and the sequential execution unit.
interface alu_seq_exec_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [3:0]            ALU_Operation_i;
    logic [DATA_WIDTH-1:0] A_i;
    logic [DATA_WIDTH-1:0] B_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DATA_WIDTH-1:0] ALU_Result_o;
    logic                  Zero_o;

    modport master (
        output start_i, ALU_Operation_i, A_i, B_i,
        input  busy_o, done_o, ALU_Result_o, Zero_o
    );

    modport slave (
        input  start_i, ALU_Operation_i, A_i, B_i,
        output busy_o, done_o, ALU_Result_o, Zero_o
    );
endinterface

// File: rtl/alu_seq_exec_shift_iter.sv
// One-bit-per-clock shifter: shift register, down-counter and
// direction bit; last_o flags the final step.
module alu_shift_iter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic                   step_i,
    input  logic                   left_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   last_o,
    output logic [DATA_WIDTH-1:0]  next_o
);

    logic [DATA_WIDTH-1:0]  sr_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic                   left_q;

    assign next_o = left_q ? (sr_q << 1) : (sr_q >> 1);
    assign last_o = (cnt_q == SHAMT_WIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else if (load_i) begin
            sr_q   <= data_i;
            cnt_q  <= shamt_i;
            left_q <= left_i;
        end else if (step_i) begin
            sr_q   <= next_o;
            cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle ops finish in one registered cycle,
// SRL/SLL iterate one bit per clock behind a start/busy/done handshake.
module alu_seq_exec
    import alu_seq_exec_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic           clk,
    input  logic           reset,
    alu_seq_exec_if.slave  bus
);

    logic [1:0]             state_q, state_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic [DATA_WIDTH-1:0]  alu_res;
    logic [DATA_WIDTH-1:0]  sh_next;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   accept;
    logic                   is_shift;
    logic                   load;
    logic                   step;
    logic                   last;

    assign shamt    = bus.B_i[SHAMT_WIDTH-1:0];
    assign accept   = (state_q == ST_IDLE) && bus.start_i;
    assign is_shift = (bus.ALU_Operation_i == ALU_SRL) ||
                      (bus.ALU_Operation_i == ALU_SLL);
    assign load     = accept && is_shift;
    assign step     = (state_q == ST_SHIFT);

    always_comb begin
        alu_res = '0;
        case (bus.ALU_Operation_i)
            ALU_ADD: alu_res = bus.A_i + bus.B_i;
            ALU_SUB: alu_res = bus.A_i - bus.B_i;
            ALU_AND: alu_res = bus.A_i & bus.B_i;
            ALU_OR:  alu_res = bus.A_i | bus.B_i;
            ALU_LUI: alu_res = bus.B_i;
            default: alu_res = '0;
        endcase
    end

    alu_shift_iter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .step_i  (step),
        .left_i  (bus.ALU_Operation_i == ALU_SLL),
        .data_i  (bus.A_i),
        .shamt_i (shamt),
        .last_o  (last),
        .next_o  (sh_next)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (!is_shift) begin
                        result_d = alu_res;
                        state_d  = ST_DONE;
                    end else if (shamt == '0) begin
                        // zero shift bypasses the iterator entirely
                        result_d = bus.A_i;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (last) begin
                    result_d = sh_next;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.done_o       = (state_q == ST_DONE);
    assign bus.ALU_Result_o = result_q;
    assign bus.Zero_o       = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec with hand-computed expectations.
module tb_alu_seq_exec;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   lat;
    int   ndone;

    alu_seq_exec_if #(.DATA_WIDTH(32)) bus ();

    alu_seq_exec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.start_i         = 1'b1;
        bus.ALU_Operation_i = op;
        bus.A_i             = a;
        bus.B_i             = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.A_i     = 32'hDEAD_BEEF;
        bus.B_i     = 32'h0BAD_F00D;
    endtask

    // counts falling edges after the accept edge until done_o is seen;
    // poke raises start_i with an ADD on a few of those cycles
    task automatic wait_done(input bit poke, output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.done_o === 1'b1) begin
                n = i;
                break;
            end
            if (poke && (i == 3 || i == 10 || i == 20)) begin
                bus.start_i         = 1'b1;
                bus.ALU_Operation_i = 4'b0000;
                bus.A_i             = 32'h1;
                bus.B_i             = 32'h1;
            end
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        n_pass              = 0;
        n_total             = 0;
        reset               = 1'b0;
        bus.start_i         = 1'b0;
        bus.ALU_Operation_i = 4'b0000;
        bus.A_i             = '0;
        bus.B_i             = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);
        chk("rst_done", 32'(bus.done_o), 32'h0);
        chk("rst_res", bus.ALU_Result_o, 32'h0);
        chk("rst_zero", 32'(bus.Zero_o), 32'h1);
        reset = 1'b1;

        issue(4'b0000, 32'd5, 32'd7);
        wait_done(1'b0, lat);
        chk("add_lat", 32'(lat), 32'd1);
        chk("add_busy", 32'(bus.busy_o), 32'h1);
        chk("add_res", bus.ALU_Result_o, 32'd12);
        chk("add_zero", 32'(bus.Zero_o), 32'h0);
        @(negedge clk);
        chk("add_idle_busy", 32'(bus.busy_o), 32'h0);
        chk("add_idle_done", 32'(bus.done_o), 32'h0);
        chk("add_hold", bus.ALU_Result_o, 32'd12);

        issue(4'b0001, 32'd9, 32'd9);
        wait_done(1'b0, lat);
        chk("sub0_res", bus.ALU_Result_o, 32'h0);
        chk("sub0_zero", 32'(bus.Zero_o), 32'h1);

        issue(4'b0001, 32'd0, 32'd1);
        wait_done(1'b0, lat);
        chk("subwrap_res", bus.ALU_Result_o, 32'hFFFF_FFFF);

        issue(4'b0111, 32'h1, 32'd31);
        @(negedge clk);
        chk("sll_busy", 32'(bus.busy_o), 32'h1);
        chk("sll_nochg", bus.ALU_Result_o, 32'hFFFF_FFFF);
        wait_done(1'b1, lat);
        chk("sll_lat", 32'(lat + 1), 32'd32);
        chk("sll_res", bus.ALU_Result_o, 32'h8000_0000);
        @(negedge clk);
        chk("sll_after_busy", 32'(bus.busy_o), 32'h0);
        chk("sll_after_res", bus.ALU_Result_o, 32'h8000_0000);

        issue(4'b0110, 32'h8000_0000, 32'h20);
        wait_done(1'b0, lat);
        chk("srl0_lat", 32'(lat), 32'd1);
        chk("srl0_res", bus.ALU_Result_o, 32'h8000_0000);

        issue(4'b0110, 32'hF000_0000, 32'd4);
        wait_done(1'b0, lat);
        chk("srl4_lat", 32'(lat), 32'd5);
        chk("srl4_res", bus.ALU_Result_o, 32'h0F00_0000);

        issue(4'b0101, 32'h0, 32'h1234_5000);
        wait_done(1'b0, lat);
        chk("lui_res", bus.ALU_Result_o, 32'h1234_5000);

        issue(4'b0100, 32'd3, 32'd4);
        wait_done(1'b0, lat);
        chk("undef_lat", 32'(lat), 32'd1);
        chk("undef_res", bus.ALU_Result_o, 32'h0);

        issue(4'b0010, 32'h0000_F0F0, 32'h0000_FF00);
        wait_done(1'b0, lat);
        chk("and_res", bus.ALU_Result_o, 32'h0000_F000);

        issue(4'b0011, 32'h0000_F0F0, 32'h0000_0F0F);
        wait_done(1'b0, lat);
        chk("or_res", bus.ALU_Result_o, 32'h0000_FFFF);

        issue(4'b0110, 32'h0000_00F0, 32'd4);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy_o), 32'h0);
        chk("midrst_done", 32'(bus.done_o), 32'h0);
        chk("midrst_res", bus.ALU_Result_o, 32'h0);
        chk("midrst_zero", 32'(bus.Zero_o), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0) ndone++;
        end
        chk("midrst_nodone", 32'(ndone), 32'h0);
        chk("midrst_hold", bus.ALU_Result_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
